// File: rtl/fifo_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_uart_pkg
// Purpose  : Shared definitions for the FIFO-draining UART transmitter:
//            FSM state encoding, parity mode constants and a helper that
//            returns the number of bit times in one frame.
// Ports    : (package, no ports)
// Revision : 1.0 - initial release
// ============================================================================
package fifo_uart_pkg;

  // FSM state encoding, 3 bits wide.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_PAR   = 3'd4;
  localparam logic [2:0] ST_STOP  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_FETCH = ST_FETCH,
    S_START = ST_START,
    S_DATA  = ST_DATA,
    S_PAR   = ST_PAR,
    S_STOP  = ST_STOP
  } state_e;

  // Parity modes.
  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Number of bit times in one frame: start + data + optional parity + stop(s).
  function automatic int frame_bits(input int data_width,
                                    input int parity,
                                    input int stop_bits);
    return 1 + data_width + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_uart_tx_bit_timer.sv
`default_nettype none
// ============================================================================
// Module   : uart_bit_timer
// Purpose  : Bit-period timer. Counts 0..CLKS_PER_BIT-1 while run is high and
//            pulses bit_tick on the last count of each bit period. Held at
//            zero while run is low so every frame starts on a fresh period.
// Ports    : clk_i     - clock
//            resetn_i  - synchronous active-low reset
//            run       - count enable; clears the counter when low
//            bit_tick  - one-cycle pulse at count CLKS_PER_BIT-1
// Revision : 1.0 - initial release
// ============================================================================
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk_i,
  input  logic resetn_i,
  input  logic run,
  output logic bit_tick
);

  localparam int                 CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = '0;
    if (run && (count_q != CNT_LAST)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign bit_tick = run && (count_q == CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : fifo_uart_tx
// Purpose  : Drains bytes from a fifo_sync read port and serialises each one
//            onto a UART TX line (8N1 / 8E1 / 8O1, one or two stop bits).
// Ports    : clk_i       - clock, all logic on posedge
//            resetn_i    - synchronous active-low reset
//            enable_i    - permits starting new frames
//            fifo_empty  - FIFO empty flag
//            fifo_data   - FIFO read data
//            fifo_r_en   - single-cycle pop strobe to the FIFO
//            tx_o        - UART line, idle high
//            busy_o      - high from the pop cycle through the last stop bit
// Revision : 1.0 - initial release
// ============================================================================
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int RD_LATENCY   = 1,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk_i,
  input  logic                  resetn_i,
  input  logic                  enable_i,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_r_en,
  output logic                  tx_o,
  output logic                  busy_o
);

  localparam int               IDX_W    = $clog2(DATA_WIDTH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);
  localparam logic             PAR_INV  = (PARITY == PARITY_ODD) ? 1'b1 : 1'b0;

  state_e                 state_q,    state_d;
  logic [DATA_WIDTH-1:0]  shift_q,    shift_d;
  logic [IDX_W-1:0]       bit_idx_q,  bit_idx_d;
  logic                   stop_idx_q, stop_idx_d;
  logic                   parity_q,   parity_d;
  logic                   tx_q,       tx_d;

  logic pop;
  logic timer_run;
  logic bit_tick;

  // The pop strobe is decoded from the registered state so that it is high
  // in exactly the IDLE cycle that decides to start a frame. Gating with
  // resetn_i keeps a byte from being popped in a cycle whose state is about
  // to be discarded by reset.
  assign pop = resetn_i && enable_i && !fifo_empty && (state_q == S_IDLE);

  // The timer only runs while bits are on the line, so START always begins
  // on a fresh bit period.
  assign timer_run = (state_q == S_START) || (state_q == S_DATA) ||
                     (state_q == S_PAR)   || (state_q == S_STOP);

  uart_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk_i    (clk_i),
    .resetn_i (resetn_i),
    .run      (timer_run),
    .bit_tick (bit_tick)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    parity_d   = parity_q;
    tx_d       = tx_q;

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (pop) begin
          if (RD_LATENCY == 0) begin
            shift_d  = fifo_data;
            parity_d = 1'b0;
            tx_d     = 1'b0;
            state_d  = S_START;
          end else begin
            state_d  = S_FETCH;
          end
        end
      end

      S_FETCH: begin
        shift_d  = fifo_data;
        parity_d = 1'b0;
        tx_d     = 1'b0;
        state_d  = S_START;
      end

      S_START: begin
        if (bit_tick) begin
          state_d   = S_DATA;
          bit_idx_d = '0;
          tx_d      = shift_q[0];
          parity_d  = shift_q[0];
        end
      end

      // tx_q always holds shift_q[0]; the next bit to send is shift_q[1].
      // The parity accumulator folds in each bit as it goes onto the line.
      S_DATA: begin
        if (bit_tick) begin
          if (bit_idx_q == IDX_LAST) begin
            if (PARITY != PARITY_NONE) begin
              state_d = S_PAR;
              tx_d    = parity_q ^ PAR_INV;
            end else begin
              state_d    = S_STOP;
              tx_d       = 1'b1;
              stop_idx_d = 1'b0;
            end
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
            parity_d  = parity_q ^ shift_q[1];
          end
        end
      end

      S_PAR: begin
        if (bit_tick) begin
          state_d    = S_STOP;
          tx_d       = 1'b1;
          stop_idx_d = 1'b0;
        end
      end

      S_STOP: begin
        if (bit_tick) begin
          if ((STOP_BITS == 2) && !stop_idx_q) begin
            stop_idx_d = 1'b1;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      parity_q   <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      parity_q   <= parity_d;
      tx_q       <= tx_d;
    end
  end

  assign fifo_r_en = pop;
  assign tx_o      = tx_q;
  // busy covers the pop cycle itself, before the state register has moved.
  assign busy_o    = (state_q != S_IDLE) || pop;

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_uart_tx
// Purpose  : Self-checking bench for fifo_uart_tx. DUT 0 runs 8N1 with a
//            FIFO model (read latency 1); DUTs 1 and 2 run even and odd
//            parity, each fed a single 0xA5 byte.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_uart_tx;
  import fifo_uart_pkg::*;

  localparam int CPB = 4;

  logic       clk;
  logic       resetn;
  logic       enable;
  logic [2:0] ren;
  logic [2:0] tx;
  logic [2:0] busy;
  logic [2:0] emp;
  logic [7:0] fdata0;
  logic [7:0] pdata;

  int n_vec = 0;
  int n_bad = 0;

  // FIFO model for DUT 0: bytes written by the stimulus, read registered.
  logic [7:0] mem [0:31];
  int npush0 = 0;
  int npop0  = 0;
  int uf     = 0;
  // Parity DUTs: a byte is available while pops < allowed.
  int allow1 = 0, allow2 = 0, npop1 = 0, npop2 = 0;

  assign emp[0] = (npop0 >= npush0);
  assign emp[1] = (npop1 >= allow1);
  assign emp[2] = (npop2 >= allow2);
  assign pdata  = 8'hA5;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ren[0]) begin
      fdata0 <= mem[npop0 % 32];
      npop0  <= npop0 + 1;
    end
    if ((ren[0] && emp[0]) || (ren[1] && emp[1]) || (ren[2] && emp[2])) uf <= uf + 1;
    if (ren[1]) npop1 <= npop1 + 1;
    if (ren[2]) npop2 <= npop2 + 1;
  end

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .RD_LATENCY(1), .PARITY(0), .STOP_BITS(1)) u_dut0 (
    .clk_i(clk), .resetn_i(resetn), .enable_i(enable), .fifo_empty(emp[0]),
    .fifo_data(fdata0), .fifo_r_en(ren[0]), .tx_o(tx[0]), .busy_o(busy[0]));

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .RD_LATENCY(1), .PARITY(1), .STOP_BITS(1)) u_dut1 (
    .clk_i(clk), .resetn_i(resetn), .enable_i(enable), .fifo_empty(emp[1]),
    .fifo_data(pdata), .fifo_r_en(ren[1]), .tx_o(tx[1]), .busy_o(busy[1]));

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .RD_LATENCY(1), .PARITY(2), .STOP_BITS(1)) u_dut2 (
    .clk_i(clk), .resetn_i(resetn), .enable_i(enable), .fifo_empty(emp[2]),
    .fifo_data(pdata), .fifo_r_en(ren[2]), .tx_o(tx[2]), .busy_o(busy[2]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push0(input logic [7:0] b);
    mem[npush0 % 32] = b;
    npush0++;
  endtask

  // Waits for a pop on DUT k, then checks every cycle of the frame.
  // exp bit i is the i-th bit time on the line (bit 0 = start).
  task automatic run_frame(input int k, input logic [11:0] exp, input int nbits,
                           input int exp_wait, input bit idle_after,
                           input int drop_at, input string name);
    int w;
    logic e;
    w = 0;
    #1;
    while (!ren[k] && w < 400) begin
      step();
      w++;
    end
    if (!ren[k]) begin
      chk({name, "_pop_timeout"}, 32'd0, 32'd1);
      return;
    end
    if (exp_wait >= 0) chk({name, "_gap"}, w, exp_wait);
    chk({name, "_pop_busy"}, busy[k], 1);
    chk({name, "_pop_tx"}, tx[k], 1);
    for (int c = 1; c <= 1 + CPB * nbits; c++) begin
      step();
      e = (c == 1) ? 1'b1 : exp[(c - 2) / CPB];
      chk({name, "_tx"}, tx[k], e);
      chk({name, "_ren"}, ren[k], 0);
      chk({name, "_busy"}, busy[k], 1);
      if (c == drop_at) enable = 1'b0;
    end
    if (idle_after) begin
      step();
      chk({name, "_idle_busy"}, busy[k], 0);
      chk({name, "_idle_tx"}, tx[k], 1);
    end
  endtask

  typedef struct {
    int          k;
    logic [7:0]  data;
    logic [11:0] exp;
    int          nbits;
    int          exp_wait;
    bit          idle_after;
    string       name;
  } vec_t;

  vec_t vt [6];

  initial begin
    int w;
    vt[0] = '{0, 8'hA5, 12'b00_1_10100101_0, frame_bits(8, 0, 1), 0, 1'b0, "a5_8n1"};
    vt[1] = '{0, 8'h00, 12'b00_1_00000000_0, frame_bits(8, 0, 1), 1, 1'b0, "b2b_00"};
    vt[2] = '{0, 8'hFF, 12'b00_1_11111111_0, frame_bits(8, 0, 1), 1, 1'b0, "b2b_ff"};
    vt[3] = '{0, 8'h3C, 12'b00_1_00111100_0, frame_bits(8, 0, 1), 1, 1'b1, "b2b_3c"};
    vt[4] = '{1, 8'hA5, 12'b0_1_0_10100101_0, frame_bits(8, 1, 1), 0, 1'b1, "a5_even"};
    vt[5] = '{2, 8'hA5, 12'b0_1_1_10100101_0, frame_bits(8, 2, 1), 0, 1'b1, "a5_odd"};

    resetn = 1'b0;
    enable = 1'b1;
    repeat (3) step();
    resetn = 1'b1;

    // Idle with empty FIFO: line stays high, no pops, not busy.
    for (int i = 0; i < 50; i++) begin
      step();
      chk("idle_tx", tx[0], 1);
      chk("idle_ren", ren[0], 0);
      chk("idle_busy", busy[0], 0);
    end

    // Queue all DUT 0 bytes so the frames run back to back.
    foreach (vt[i]) if (vt[i].k == 0) push0(vt[i].data);

    foreach (vt[i]) begin
      if (vt[i].k == 1) allow1++;
      if (vt[i].k == 2) allow2++;
      run_frame(vt[i].k, vt[i].exp, vt[i].nbits, vt[i].exp_wait,
                vt[i].idle_after, -1, vt[i].name);
    end
    chk("pops_after_table", npop0, 4);

    // enable_i dropped 10 cycles into a frame with three bytes queued.
    push0(8'h11);
    push0(8'h22);
    push0(8'h33);
    run_frame(0, 12'b00_1_00010001_0, 10, 0, 1'b1, 10, "en_drop");
    for (int i = 0; i < 20; i++) begin
      step();
      chk("en_off_ren", ren[0], 0);
      chk("en_off_busy", busy[0], 0);
    end
    chk("en_off_pops", npop0, 5);
    enable = 1'b1;
    run_frame(0, 12'b00_1_00100010_0, 10, 0, 1'b0, -1, "en_back_22");
    run_frame(0, 12'b00_1_00110011_0, 10, 1, 1'b1, -1, "en_back_33");

    // One-cycle reset in the middle of the data bits.
    push0(8'h5A);
    push0(8'h6B);
    w = 0;
    #1;
    while (!ren[0] && w < 400) begin
      step();
      w++;
    end
    chk("rst_pop_seen", ren[0], 1);
    repeat (16) step();
    chk("rst_pre_tx", tx[0], 0);
    resetn = 1'b0;
    enable = 1'b0;
    step();
    chk("rst_tx", tx[0], 1);
    chk("rst_busy", busy[0], 0);
    chk("rst_ren", ren[0], 0);
    resetn = 1'b1;
    step();
    chk("rst_after_busy", busy[0], 0);
    chk("rst_after_tx", tx[0], 1);
    enable = 1'b1;
    run_frame(0, 12'b00_1_01101011_0, 10, 0, 1'b1, -1, "rst_next_6b");

    chk("total_pops0", npop0, 9);
    chk("total_pops1", npop1, 1);
    chk("total_pops2", npop2, 1);
    chk("no_underflow", uf, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
